spi_slave_responder: RTL and testbench

SPI slave (responder) matching the team's `spi_master_slave` master: receives 8-bit frames on MOSI and returns 8-bit frames on MISO, mode 0 (CPOL=0, CPHA=0), MSB first. All SPI pins are oversampled in the single `clk` domain; there is no logic clocked by `sclk`. It sits behind the chip pins on the slave die and gives the core a byte-wide load/valid interface, e.g. for the multiplier operand/result path.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_responder_if.sv | 32 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_responder.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave (responder) blocks:
// default frame width, idle MISO fill byte and the responder FSM states.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 8;
  localparam logic [SPI_FRAME_BITS-1:0] SPI_IDLE_FILL = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_t;

endpackage

// File: rtl/spi_slave_responder_if.sv
// SPI pin bundle plus the byte-wide core-side load/valid interface of the
// responder. The slave modport is the responder's view; the master modport is
// the view of whatever drives the pins and the TX byte (master die + core).
interface spi_slave_responder_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS
);

  logic                  cs_bar;
  logic                  sclk;
  logic                  din_mosi;
  logic                  dout_miso;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  cs_bar, sclk, din_mosi, tx_data, tx_load,
    output dout_miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output cs_bar, sclk, din_mosi, tx_data, tx_load,
    input  dout_miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop that turns
// level changes of the synchronized signal into one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and edge-history flop, cleared to the pin's idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB first, fully oversampled in the clk domain.
// Received frames are presented as rx_data/rx_valid; the core preloads the
// next MISO byte through a one-deep TX holding buffer (tx_load/tx_ready).
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int                    FRAME_BITS = SPI_FRAME_BITS,
  parameter logic [FRAME_BITS-1:0] IDLE_FILL  = SPI_IDLE_FILL
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_slave_responder_if.slave bus
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  spi_slv_state_t r_state;
  spi_slv_state_t w_state_nxt;

  logic [FRAME_BITS-1:0] r_tx_sr,   w_tx_sr_nxt;
  logic [FRAME_BITS-1:0] r_rx_sr,   w_rx_sr_nxt;
  logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
  logic [FRAME_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  r_dout,    w_dout_nxt;
  logic [FRAME_BITS-1:0] r_buf,     w_buf_nxt;
  logic                  r_full,    w_full_nxt;

  logic                  r_mosi_meta;
  logic                  r_mosi_sync;

  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_cs_rise;
  logic                  w_cs_fall;
  logic                  w_buf_read;
  logic                  w_full_after_read;
  logic [FRAME_BITS-1:0] w_fill;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(bus.sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(bus.cs_bar),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // MOSI only needs a level, so a plain two-flop synchronizer suffices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= bus.din_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Next MISO byte: pending buffer content, otherwise the idle fill pattern
  assign w_fill = r_full ? r_buf : IDLE_FILL;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift/count datapath, output pulses and TX buffer update
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_sr_nxt     = r_tx_sr;
    w_rx_sr_nxt     = r_rx_sr;
    w_cnt_nxt       = r_cnt;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_dout_nxt      = 1'b0;
    w_buf_read      = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // A same-cycle sclk rise is dropped here: the load wins
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_tx_sr_nxt = w_fill;
          w_buf_read  = 1'b1;
          // First bit goes straight to the pin so it appears with busy
          w_dout_nxt  = w_fill[FRAME_BITS-1];
        end
      end

      SHIFT: begin
        w_dout_nxt = r_tx_sr[FRAME_BITS-1];
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_dout_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          if (r_cnt == CNT_FULL) begin
            // Last bit landed just before deselect: the frame is still good
            w_rx_data_nxt  = r_rx_sr;
            w_rx_valid_nxt = 1'b1;
          end else if (r_cnt != '0) begin
            w_frame_err_nxt = 1'b1;
          end
        end else if (r_cnt == CNT_FULL) begin
          // Publish one cycle after the last bit is shifted in
          w_rx_data_nxt  = r_rx_sr;
          w_rx_valid_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else if (w_sclk_rise) begin
          w_rx_sr_nxt = {r_rx_sr[FRAME_BITS-2:0], r_mosi_sync};
          w_cnt_nxt   = r_cnt + 1'b1;
        end else if (w_sclk_fall) begin
          // A fall with the counter at zero follows a completed frame:
          // start the next back-to-back frame from the buffer
          if (r_cnt == '0) begin
            w_tx_sr_nxt = w_fill;
            w_buf_read  = 1'b1;
          end else begin
            w_tx_sr_nxt = {r_tx_sr[FRAME_BITS-2:0], 1'b0};
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A read always empties the buffer, so a coincident load is then accepted
    w_full_after_read = r_full & ~w_buf_read;
    w_buf_nxt         = r_buf;
    w_full_nxt        = w_full_after_read;
    if (bus.tx_load && !w_full_after_read) begin
      w_buf_nxt  = bus.tx_data;
      w_full_nxt = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_cnt       <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_dout      <= 1'b0;
      r_buf       <= '0;
      r_full      <= 1'b0;
    end else begin
      r_tx_sr     <= w_tx_sr_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_dout      <= w_dout_nxt;
      r_buf       <= w_buf_nxt;
      r_full      <= w_full_nxt;
    end
  end

  assign bus.dout_miso = r_dout;
  assign bus.tx_ready  = ~r_full;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a clk-synchronous SPI master model
// drives the pins, expected RX/MISO bytes go into scoreboard queues when a
// frame is started and are popped when the DUT delivers them.
module tb_spi_slave_responder;
  import spi_pkg::*;

  localparam int H = 8;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_slave_responder_if #(.FRAME_BITS(8)) bus ();

  spi_slave_responder #(
    .FRAME_BITS(8),
    .IDLE_FILL (8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int rxv_cnt  = 0;
  int ferr_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rx_valid cycle pops one expected byte
  always @(posedge clk) begin
    #1;
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      n_cmp++;
      assert (exp_rx.size() > 0) else begin
        n_err++;
        $error("FAIL rx_unexpected: observed %02h expected no rx_valid", bus.rx_data);
      end
      if (exp_rx.size() > 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    wait_clk(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic cs_fall(input logic exp_msb);
    bus.cs_bar = 1'b0;
    wait_clk(2);
    chk("busy_before_3clk", 32'(bus.busy), 32'd0);
    wait_clk(1);
    chk("busy_at_3clk", 32'(bus.busy), 32'd1);
    chk("miso_first_bit", 32'(bus.dout_miso), 32'(exp_msb));
    chk("tx_ready_at_cs", 32'(bus.tx_ready), 32'd1);
    wait_clk(2);
  endtask

  task automatic cs_rise();
    wait_clk(H);
    bus.cs_bar = 1'b1;
    wait_clk(H);
    bus.sclk = 1'b0;
    wait_clk(4);
  endtask

  // Even edge index = sclk rise (MISO sampled just before), odd = fall
  task automatic xfer(input logic [7:0] mosi, input int nedges, input int load_edge,
                      input logic [7:0] load_val, output logic [7:0] miso);
    miso = 8'h00;
    for (int e = 0; e < nedges; e++) begin
      if (e == load_edge) tx_push(load_val);
      if (e % 2 == 0) begin
        bus.din_mosi = mosi[7 - (e / 2)];
        wait_clk(H);
        miso = {miso[6:0], bus.dout_miso};
        bus.sclk = 1'b1;
      end else begin
        wait_clk(H);
        bus.sclk = 1'b0;
      end
    end
  endtask

  task automatic full_frame(input logic [7:0] mosi, input logic [7:0] miso_exp);
    logic [7:0] got;
    exp_rx.push_back(mosi);
    exp_miso.push_back(miso_exp);
    cs_fall(miso_exp[7]);
    xfer(mosi, 16, -1, 8'h00, got);
    chk("miso_byte", 32'(got), 32'(exp_miso.pop_front()));
    cs_rise();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"},      32'(bus.dout_miso), 32'd0);
    chk({tag, "_tx_ready"},  32'(bus.tx_ready),  32'd1);
    chk({tag, "_rx_data"},   32'(bus.rx_data),   32'd0);
    chk({tag, "_rx_valid"},  32'(bus.rx_valid),  32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got;
    bus.cs_bar   = 1'b1;
    bus.sclk     = 1'b0;
    bus.din_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_load  = 1'b0;
    reset        = 1'b1;
    wait_clk(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    wait_clk(2);

    // Preloaded TX byte, single frame
    tx_push(8'hF1);
    chk("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
    full_frame(8'hA5, 8'hF1);
    chk("rx_hold_a5", 32'(bus.rx_data), 32'h0000_00A5);
    chk("rxv_cnt_1", 32'(rxv_cnt), 32'd1);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("miso_idle", 32'(bus.dout_miso), 32'd0);

    // No TX byte pending: idle fill on MISO
    full_frame(8'h3C, 8'h00);
    chk("rx_hold_3c", 32'(bus.rx_data), 32'h0000_003C);
    chk("rxv_cnt_2", 32'(rxv_cnt), 32'd2);

    // Back-to-back frames under one chip select, second TX byte loaded mid-frame
    tx_push(8'h55);
    exp_rx.push_back(8'h01);
    exp_rx.push_back(8'h80);
    exp_miso.push_back(8'h55);
    exp_miso.push_back(8'hAA);
    cs_fall(1'b0);
    xfer(8'h01, 16, 4, 8'hAA, got);
    chk("miso_b2b_0", 32'(got), 32'(exp_miso.pop_front()));
    xfer(8'h80, 16, -1, 8'h00, got);
    chk("miso_b2b_1", 32'(got), 32'(exp_miso.pop_front()));
    cs_rise();
    chk("rxv_cnt_4", 32'(rxv_cnt), 32'd4);
    chk("rx_hold_80", 32'(bus.rx_data), 32'h0000_0080);
    chk("ferr_cnt_0", 32'(ferr_cnt), 32'd0);

    // Chip select dropped after 5 sclk edges
    cs_fall(1'b0);
    xfer(8'hFF, 5, -1, 8'h00, got);
    cs_rise();
    chk("ferr_cnt_1", 32'(ferr_cnt), 32'd1);
    chk("rxv_cnt_after_abort", 32'(rxv_cnt), 32'd4);
    chk("rx_kept_after_abort", 32'(bus.rx_data), 32'h0000_0080);
    chk("busy_after_abort", 32'(bus.busy), 32'd0);
    full_frame(8'h5A, 8'h00);
    chk("rxv_cnt_5", 32'(rxv_cnt), 32'd5);

    // Load while buffer full is ignored
    tx_push(8'h11);
    chk("tx_ready_full", 32'(bus.tx_ready), 32'd0);
    tx_push(8'h22);
    chk("tx_ready_still_full", 32'(bus.tx_ready), 32'd0);
    full_frame(8'h96, 8'h11);
    full_frame(8'h69, 8'h00);
    chk("rxv_cnt_7", 32'(rxv_cnt), 32'd7);

    // Reset in the middle of a frame
    tx_push(8'h7E);
    cs_fall(1'b0);
    xfer(8'hE7, 6, -1, 8'h00, got);
    reset        = 1'b1;
    bus.cs_bar   = 1'b1;
    bus.sclk     = 1'b0;
    wait_clk(1);
    chk_reset_vals("midreset");
    reset = 1'b0;
    wait_clk(2);
    chk("ferr_cnt_after_reset", 32'(ferr_cnt), 32'd1);
    chk("rxv_cnt_after_reset", 32'(rxv_cnt), 32'd7);
    full_frame(8'hC3, 8'h00);
    chk("rx_hold_c3", 32'(bus.rx_data), 32'h0000_00C3);
    chk("rxv_cnt_8", 32'(rxv_cnt), 32'd8);

    wait_clk(4);
    chk("exp_rx_drained", 32'(exp_rx.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
